// File: rtl/alu_pipe_pkg.sv
// Shared opcodes, wide arithmetic type and range helpers for the pipelined ALU.
// Wide intermediates are 64 bits, so DATA_W may be at most 31.
package alu_pipe_pkg;

    localparam logic [2:0] OP_ADD    = 3'd0;
    localparam logic [2:0] OP_SUB    = 3'd1;
    localparam logic [2:0] OP_MUL    = 3'd2;
    localparam logic [2:0] OP_MAC    = 3'd3;
    localparam logic [2:0] OP_XNOR   = 3'd4;
    localparam logic [2:0] OP_RELU   = 3'd5;
    localparam logic [2:0] OP_MEAN   = 3'd6;
    localparam logic [2:0] OP_ABSMAX = 3'd7;

    localparam int WIDE_W = 64;
    typedef logic signed [WIDE_W-1:0] wide_t;

    function automatic logic fits_signed(input wide_t v, input int w);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = -(wide_t'(1) <<< (w - 1));
        return (v <= hi) && (v >= lo);
    endfunction

    function automatic wide_t sat_clip(input wide_t v, input int w);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = -(wide_t'(1) <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/alu_round_sat.sv
// Fixed-point product scaler: arithmetic shift by FRAC_W with round-half-up,
// DATA_W range check and optional clamp. Shared by the mul and mac paths.
module alu_round_sat
    import alu_pipe_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int FRAC_W = 5,
    parameter int SAT_EN = 0
) (
    input  logic [2*DATA_W-1:0] i_prod,
    output logic [WIDE_W-1:0]   o_rnd,
    output logic [DATA_W-1:0]   o_res,
    output logic                o_ovf
);

    wide_t prod_w;
    wide_t shift_w;
    wide_t half_w;
    wide_t rnd_w;

    function automatic logic [DATA_W-1:0] clip_w(input wide_t v);
        wide_t c;
        c = sat_clip(v, DATA_W);
        return c[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] narrow(input wide_t v);
        return v[DATA_W-1:0];
    endfunction

    always_comb begin
        prod_w    = {{(WIDE_W-2*DATA_W){i_prod[2*DATA_W-1]}}, i_prod};
        shift_w   = prod_w >>> FRAC_W;
        half_w    = '0;
        half_w[0] = i_prod[FRAC_W-1];
        rnd_w     = shift_w + half_w;
        o_rnd     = rnd_w;
        o_ovf     = !fits_signed(rnd_w, DATA_W);
        o_res     = (SAT_EN != 0) ? clip_w(rnd_w) : narrow(rnd_w);
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined fixed-point ALU with valid/ready handshake, optional
// saturation and a chained MAC accumulator with sticky overflow.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int FRAC_W = 5,
    parameter int SAT_EN = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [2:0]        i_inst,
    input  logic              i_mac_clr,
    input  logic [DATA_W-1:0] i_data_a,
    input  logic [DATA_W-1:0] i_data_b,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_overflow
);

    localparam wide_t ZERO_W = '0;

    logic advance;
    logic accept;

    logic signed [2*DATA_W-1:0] a_x_p0;
    logic signed [2*DATA_W-1:0] b_x_p0;

    logic                       vld_p1;
    logic [2:0]                 op_p1;
    logic                       clr_p1;
    logic signed [DATA_W:0]     a_p1;
    logic signed [DATA_W:0]     b_p1;
    logic signed [2*DATA_W-1:0] prod_p1;

    logic                       vld_p2;
    logic [DATA_W-1:0]          data_p2;
    logic                       ovf_p2;
    logic signed [DATA_W-1:0]   acc_p2;
    logic                       sticky_p2;

    logic [WIDE_W-1:0] rs_rnd;
    logic [DATA_W-1:0] rs_res;
    logic              rs_ovf;

    wide_t             a_w;
    wide_t             b_w;
    wide_t             acc_w;
    wide_t             prev_w;
    wide_t             rnd_w;
    wide_t             sum_w;
    wide_t             abs_a_w;
    wide_t             abs_b_w;
    wide_t             res_w;
    logic              mac_ovf_c;
    logic              ovf_c;
    logic [DATA_W-1:0] data_c;

    function automatic logic [DATA_W-1:0] clip_w(input wide_t v);
        wide_t c;
        c = sat_clip(v, DATA_W);
        return c[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] narrow(input wide_t v);
        return v[DATA_W-1:0];
    endfunction

    assign advance = !vld_p2 || i_ready;
    assign accept  = i_valid && advance;
    assign o_ready = advance;

    assign a_x_p0 = {{DATA_W{i_data_a[DATA_W-1]}}, i_data_a};
    assign b_x_p0 = {{DATA_W{i_data_b[DATA_W-1]}}, i_data_b};

    // ---- stage 0 -> stage 1: capture opcode, operands and full product ----
    always_ff @(posedge i_clk) begin
        if (accept) begin
            op_p1   <= i_inst;
            clr_p1  <= i_mac_clr;
            a_p1    <= {i_data_a[DATA_W-1], i_data_a};
            b_p1    <= {i_data_b[DATA_W-1], i_data_b};
            prod_p1 <= a_x_p0 * b_x_p0;
        end
    end

    alu_round_sat #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .SAT_EN (SAT_EN)
    ) u_round_sat (
        .i_prod (prod_p1),
        .o_rnd  (rs_rnd),
        .o_res  (rs_res),
        .o_ovf  (rs_ovf)
    );

    // ---- stage 1 -> stage 2: result, overflow and MAC state ----
    always_comb begin
        a_w     = {{(WIDE_W-DATA_W-1){a_p1[DATA_W]}}, a_p1};
        b_w     = {{(WIDE_W-DATA_W-1){b_p1[DATA_W]}}, b_p1};
        acc_w   = {{(WIDE_W-DATA_W){acc_p2[DATA_W-1]}}, acc_p2};
        rnd_w   = rs_rnd;
        prev_w  = clr_p1 ? ZERO_W : acc_w;
        sum_w   = a_w + b_w;
        abs_a_w = (a_w < ZERO_W) ? -a_w : a_w;
        abs_b_w = (b_w < ZERO_W) ? -b_w : b_w;
        res_w     = ZERO_W;
        mac_ovf_c = 1'b0;
        ovf_c     = 1'b0;
        case (op_p1)
            OP_ADD: begin
                res_w = sum_w;
                ovf_c = !fits_signed(res_w, DATA_W);
            end
            OP_SUB: begin
                res_w = a_w - b_w;
                ovf_c = !fits_signed(res_w, DATA_W);
            end
            OP_MUL: begin
                res_w = rnd_w;
                ovf_c = rs_ovf;
            end
            OP_MAC: begin
                res_w     = rnd_w + prev_w;
                mac_ovf_c = rs_ovf || !fits_signed(res_w, DATA_W);
                // Sticky state only survives when the chain is not being restarted.
                ovf_c     = mac_ovf_c || (sticky_p2 && !clr_p1);
            end
            OP_XNOR: res_w = ~(a_w ^ b_w);
            OP_RELU: res_w = (a_w > ZERO_W) ? a_w : ZERO_W;
            OP_MEAN: res_w = sum_w >>> 1;
            default: begin
                res_w = (abs_a_w > abs_b_w) ? abs_a_w : abs_b_w;
                ovf_c = !fits_signed(res_w, DATA_W);
            end
        endcase
        if (op_p1 == OP_MUL) begin
            data_c = rs_res;
        end else if (SAT_EN != 0) begin
            data_c = clip_w(res_w);
        end else begin
            data_c = narrow(res_w);
        end
    end

    always_ff @(posedge i_clk) begin
        if (advance && vld_p1) begin
            data_p2 <= data_c;
            ovf_p2  <= ovf_c;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            acc_p2    <= '0;
            sticky_p2 <= 1'b0;
        end else if (advance) begin
            vld_p1 <= i_valid;
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                if (op_p1 == OP_MAC) begin
                    acc_p2    <= data_c;
                    sticky_p2 <= mac_ovf_c || (sticky_p2 && !clr_p1);
                end else begin
                    acc_p2    <= '0;
                    sticky_p2 <= 1'b0;
                end
            end
        end
    end

    assign o_valid    = vld_p2;
    assign o_data     = vld_p2 ? data_p2 : '0;
    assign o_overflow = vld_p2 && ovf_p2;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: a wrapping and a saturating instance share one
// stimulus stream; expected values are hand-computed for DATA_W=12, FRAC_W=5.
module tb_alu_pipe;
    import alu_pipe_pkg::*;

    localparam int DW = 12;
    localparam int NV = 27;

    typedef struct {
        logic [2:0]    inst;
        logic          clr;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] d0;
        logic          o0;
        logic [DW-1:0] d1;
        logic          o1;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid;
    logic          ready_in;
    logic [2:0]    inst;
    logic          clr;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          rdy0, rdy1, ov0, ov1, of0, of1;
    logic [DW-1:0] d0, d1;

    int   n_chk  = 0;
    int   n_fail = 0;
    vec_t vecs[NV];

    always #5 clk = ~clk;

    alu_pipe #(.DATA_W(DW), .FRAC_W(5), .SAT_EN(0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(rdy0),
        .i_inst(inst), .i_mac_clr(clr), .i_data_a(a), .i_data_b(b),
        .o_valid(ov0), .i_ready(ready_in), .o_data(d0), .o_overflow(of0)
    );

    alu_pipe #(.DATA_W(DW), .FRAC_W(5), .SAT_EN(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(rdy1),
        .i_inst(inst), .i_mac_clr(clr), .i_data_a(a), .i_data_b(b),
        .o_valid(ov1), .i_ready(ready_in), .o_data(d1), .o_overflow(of1)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_out(input string nm, input logic v,
                             input logic [DW-1:0] e0, input logic eo0,
                             input logic [DW-1:0] e1, input logic eo1);
        check({nm, " wrap valid"}, 32'(ov0), 32'(v));
        check({nm, " sat valid"},  32'(ov1), 32'(v));
        check({nm, " wrap data"},  32'(d0),  32'(e0));
        check({nm, " wrap ovf"},   32'(of0), 32'(eo0));
        check({nm, " sat data"},   32'(d1),  32'(e1));
        check({nm, " sat ovf"},    32'(of1), 32'(eo1));
    endtask

    task automatic drive(input logic [2:0] op, input logic c,
                         input logic [DW-1:0] x, input logic [DW-1:0] y);
        valid = 1'b1;
        inst  = op;
        clr   = c;
        a     = x;
        b     = y;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            inst       clr   a       b       d0      o0    d1      o1
        vecs[0]  = '{OP_ADD,    1'b0, 12'h7FF, 12'h001, 12'h800, 1'b1, 12'h7FF, 1'b1};
        vecs[1]  = '{OP_SUB,    1'b0, 12'h800, 12'h001, 12'h7FF, 1'b1, 12'h800, 1'b1};
        vecs[2]  = '{OP_ADD,    1'b0, 12'h005, 12'hFFE, 12'h003, 1'b0, 12'h003, 1'b0};
        vecs[3]  = '{OP_MUL,    1'b0, 12'h040, 12'h030, 12'h060, 1'b0, 12'h060, 1'b0};
        vecs[4]  = '{OP_MUL,    1'b0, 12'h001, 12'h010, 12'h001, 1'b0, 12'h001, 1'b0};
        vecs[5]  = '{OP_MUL,    1'b0, 12'h7FF, 12'h7FF, 12'hF80, 1'b1, 12'h7FF, 1'b1};
        vecs[6]  = '{OP_MUL,    1'b0, 12'hFFF, 12'h001, 12'h000, 1'b0, 12'h000, 1'b0};
        vecs[7]  = '{OP_MAC,    1'b0, 12'h040, 12'h040, 12'h080, 1'b0, 12'h080, 1'b0};
        vecs[8]  = '{OP_MAC,    1'b0, 12'h040, 12'h040, 12'h100, 1'b0, 12'h100, 1'b0};
        vecs[9]  = '{OP_MAC,    1'b0, 12'h040, 12'h040, 12'h180, 1'b0, 12'h180, 1'b0};
        vecs[10] = '{OP_RELU,   1'b0, 12'hFF0, 12'h000, 12'h000, 1'b0, 12'h000, 1'b0};
        vecs[11] = '{OP_MAC,    1'b0, 12'h040, 12'h040, 12'h080, 1'b0, 12'h080, 1'b0};
        vecs[12] = '{OP_MAC,    1'b1, 12'h040, 12'h040, 12'h080, 1'b0, 12'h080, 1'b0};
        vecs[13] = '{OP_MAC,    1'b1, 12'h0F0, 12'h0F0, 12'h708, 1'b0, 12'h708, 1'b0};
        vecs[14] = '{OP_MAC,    1'b0, 12'h0F0, 12'h0F0, 12'hE10, 1'b1, 12'h7FF, 1'b1};
        vecs[15] = '{OP_MAC,    1'b0, 12'h040, 12'h040, 12'hE90, 1'b1, 12'h7FF, 1'b1};
        vecs[16] = '{OP_MAC,    1'b0, 12'h001, 12'h001, 12'hE90, 1'b1, 12'h7FF, 1'b1};
        vecs[17] = '{OP_RELU,   1'b0, 12'h005, 12'h000, 12'h005, 1'b0, 12'h005, 1'b0};
        vecs[18] = '{OP_MAC,    1'b0, 12'h040, 12'h040, 12'h080, 1'b0, 12'h080, 1'b0};
        vecs[19] = '{OP_XNOR,   1'b0, 12'h0F0, 12'h0FF, 12'hFF0, 1'b0, 12'hFF0, 1'b0};
        vecs[20] = '{OP_MEAN,   1'b0, 12'hFFF, 12'h000, 12'hFFF, 1'b0, 12'hFFF, 1'b0};
        vecs[21] = '{OP_MEAN,   1'b0, 12'h7FF, 12'h7FF, 12'h7FF, 1'b0, 12'h7FF, 1'b0};
        vecs[22] = '{OP_MEAN,   1'b0, 12'h800, 12'hFFF, 12'hBFF, 1'b0, 12'hBFF, 1'b0};
        vecs[23] = '{OP_ABSMAX, 1'b0, 12'h800, 12'h001, 12'h800, 1'b1, 12'h7FF, 1'b1};
        vecs[24] = '{OP_ABSMAX, 1'b0, 12'h005, 12'hF00, 12'h100, 1'b0, 12'h100, 1'b0};
        vecs[25] = '{OP_RELU,   1'b0, 12'h7FF, 12'h000, 12'h7FF, 1'b0, 12'h7FF, 1'b0};
        vecs[26] = '{OP_SUB,    1'b0, 12'h005, 12'h007, 12'hFFE, 1'b0, 12'hFFE, 1'b0};

        rst = 1'b1; valid = 1'b0; ready_in = 1'b1;
        inst = OP_ADD; clr = 1'b0; a = '0; b = '0;
        repeat (3) step();
        check_out("reset", 1'b0, '0, 1'b0, '0, 1'b0);
        rst = 1'b0;
        #1;
        check("reset ready", 32'(rdy0 & rdy1), 32'd1);

        // streamed table: result for vector i appears two edges after its accept
        for (int i = 0; i <= NV; i++) begin
            if (i < NV) drive(vecs[i].inst, vecs[i].clr, vecs[i].a, vecs[i].b);
            else valid = 1'b0;
            step();
            if (i == 0) begin
                check("latency fill", 32'(ov0 | ov1), 32'd0);
            end else begin
                check_out($sformatf("vec%0d", i - 1), 1'b1,
                          vecs[i-1].d0, vecs[i-1].o0, vecs[i-1].d1, vecs[i-1].o1);
            end
        end
        step();
        check("drained", 32'(ov0 | ov1), 32'd0);

        // backpressure: three adds issued while downstream stalls
        ready_in = 1'b0;
        drive(OP_ADD, 1'b0, 12'h001, 12'h001);
        step();
        check("bp first ready", 32'(rdy0), 32'd1);
        check("bp first valid", 32'(ov0), 32'd0);
        drive(OP_ADD, 1'b0, 12'h002, 12'h002);
        step();
        check("bp full ready", 32'(rdy0 | rdy1), 32'd0);
        check_out("bp head", 1'b1, 12'h002, 1'b0, 12'h002, 1'b0);
        drive(OP_ADD, 1'b0, 12'h003, 12'h003);
        for (int k = 0; k < 2; k++) begin
            step();
            check("bp stall ready", 32'(rdy0 | rdy1), 32'd0);
            check_out("bp stall", 1'b1, 12'h002, 1'b0, 12'h002, 1'b0);
        end
        ready_in = 1'b1;
        #1;
        check("bp release ready", 32'(rdy0 & rdy1), 32'd1);
        step();
        valid = 1'b0;
        check_out("bp drain1", 1'b1, 12'h004, 1'b0, 12'h004, 1'b0);
        step();
        check_out("bp drain2", 1'b1, 12'h006, 1'b0, 12'h006, 1'b0);
        step();
        check("bp no dup", 32'(ov0 | ov1), 32'd0);

        // reset one cycle after an accepted MAC kills it and clears the accumulator
        drive(OP_MAC, 1'b0, 12'h040, 12'h040);
        step();
        valid = 1'b0;
        step();
        check_out("rst pre mac", 1'b1, 12'h080, 1'b0, 12'h080, 1'b0);
        drive(OP_MAC, 1'b0, 12'h040, 12'h040);
        step();
        valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst kill a", 32'(ov0 | ov1), 32'd0);
        step();
        check("rst kill b", 32'(ov0 | ov1), 32'd0);
        drive(OP_MAC, 1'b0, 12'h040, 12'h040);
        step();
        valid = 1'b0;
        step();
        check_out("rst acc zero", 1'b1, 12'h080, 1'b0, 12'h080, 1'b0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, two-stage pipelined fixed-point ALU. It is the next generation of the single-cycle 12-bit ALU and keeps the same 3-bit instruction set. New features:
- Generic data and fraction widths.
- Valid/ready backpressure on input and output.
- Optional saturation in place of wrap-around.
- A MAC accumulator with sticky overflow and an explicit clear.

It sits between the operand sequencer and the result buffer of the datapath.

Parameters:
DATA_W, 12, signed two's-complement operand and result width (>=4)
FRAC_W, 5, fraction bits for mul/MAC rounding (1..DATA_W-2)
SAT_EN, 0, 1 = clamp overflowing add/sub/mul/mac/absmax results to the signed max/min; 0 = wrap

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  synchronous active-high reset
i_valid  in  1  operand valid
o_ready  out  1  block can accept operands this cycle
i_inst  in  3  opcode: 0 add, 1 sub, 2 mul, 3 mac, 4 xnor, 5 relu, 6 mean, 7 absmax
i_mac_clr  in  1  with an accepted MAC, use 0 as the previous accumulator value
i_data_a  in  DATA_W  signed operand A
i_data_b  in  DATA_W  signed operand B
o_valid  out  1  result valid
i_ready  in  1  downstream accepts result
o_data  out  DATA_W  result
o_overflow  out  1  result overflowed (wrapped or clamped)

Behaviour:
- Only one clock, i_clk, and one reset, i_rst. i_rst is synchronous and active-high.
- Reset values: o_valid=0, o_data=0, o_overflow=0, accumulator=0, sticky flag=0, both stage-valid bits=0.
- Reset asserted mid-operation drops all in-flight results; no output is produced for them.
- Handshake and pipeline advance:
  - advance = !o_valid || i_ready.
  - o_ready = advance; it is combinational and does not depend on i_valid.
  - Accept = i_valid && o_ready.
  - Stage-1 contents move to stage 2 only on advance.
  - While stalled, o_data and o_overflow are held stable.
- Latency: exactly 2 cycles from accept to o_valid when there is no stall. Throughput is 1 per cycle.
- Stage 1 registers:
  - the opcode and i_mac_clr;
  - sign-extended operands;
  - the full 2*DATA_W signed product a*b.
- Stage 2 computes the result, rounds/saturates it and updates the MAC state.
- add/sub:
  - Computed at DATA_W+1 bits.
  - Overflow when the result does not fit in DATA_W.
- mul:
  - r = (p >>> FRAC_W) + p[FRAC_W-1], computed at 2*DATA_W+1 bits (round half up).
  - Overflow when r does not fit in DATA_W.
- mac:
  - prev = 0 if i_mac_clr or the previous stage-2 op was not a MAC; otherwise prev = accumulator.
  - s = rounded_product + prev, computed at wide width.
  - The product overflow and the sum overflow are OR'd together.
  - The accumulator stores the DATA_W result (clamped when SAT_EN=1).
- MAC sticky overflow:
  - Any MAC overflow sets the sticky flag.
  - While it is set, o_overflow=1 for every subsequent chained MAC.
  - A non-MAC op, i_mac_clr, or reset clears both the accumulator and the sticky flag.
- xnor: bitwise ~(a^b).
- relu: a if a>0, else 0.
- mean: (a+b)>>>1 at DATA_W+1 bits (floor toward -inf).
- xnor, relu and mean never set o_overflow.
- absmax:
  - Result is max(|a|,|b|).
  - A magnitude of 2^(DATA_W-1) sets overflow; the output is 0x..80 when SAT_EN=0 and signed max when SAT_EN=1.
- SAT_EN=1: positive overflow gives 2^(DATA_W-1)-1 and negative overflow gives -2^(DATA_W-1). o_overflow is still asserted.
- When o_valid=0, o_data and o_overflow are 0.

Decomposition:
- Package alu_pipe_pkg holds:
  - opcode localparams (OP_ADD..OP_ABSMAX);
  - functions sat_clip(wide value, DATA_W) and fits_signed(wide value, DATA_W).
- One sub-module, alu_round_sat, is natural. It is purely combinational: wide input, FRAC_W shift with round-half-up, overflow detect, optional clamp. It is shared by mul and mac.

Test Plan (DATA_W=12, FRAC_W=5, i_ready=1 unless stated):
- add 0x7FF+0x001 -> 2 cycles later o_data=0x800, o_overflow=1. With SAT_EN=1 -> 0x7FF, o_overflow=1.
- mul 0x040*0x030 -> 0x060, ovf=0. mul 0x001*0x010 -> 0x001 (rounded up). mul 0x7FF*0x7FF -> o_overflow=1.
- Back-to-back MAC 0x040*0x040 x3 -> outputs 0x080, 0x100, 0x180. Then relu, then MAC -> 0x080. MAC with i_mac_clr=1 mid-chain -> 0x080.
- MAC chain whose sum exceeds 0x7FF -> o_overflow=1 on that MAC and on every later chained MAC, even small ones. It clears after a non-MAC op.
- Backpressure: i_ready=0 with 3 ops issued -> o_valid stays high with data stable, o_ready falls once both stages are full. Releasing i_ready drains the results in order with no loss or duplicates.
- mean 0xFFF,0x000 -> 0xFFF. absmax 0x800,0x001 -> 0x800 with ovf=1 (SAT_EN=1: 0x7FF). i_rst pulsed one cycle after an accept -> no o_valid for that op, accumulator 0.
